// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8N1, LSB first, idle-high line.
// Bytes are queued through a valid/ready port into a byte FIFO and sent
// back-to-back with no idle gap while the FIFO holds data.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit (8E1 framing).
module uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          tx
);

  // Bit period in clock cycles, rounded to nearest.
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   baud_reg, baud_next;
  logic [2:0]      idx_reg, idx_next;
  logic            tx_reg, tx_next;
  logic [7:0]      shift_reg;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            push, pop, baud_wrap, fifo_empty;

  // Full check uses the registered count only, so a pop on the same edge
  // never lets a push into a full FIFO.
  assign in_ready   = (count_reg != CW'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push       = in_valid && in_ready;
  assign baud_wrap  = (baud_reg == BW'(DIV - 1));

  assign fifo_count = count_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;
  assign tx         = tx_reg;

  // FIFO storage write port (no reset so it can map onto RAM).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  // FIFO pointers, occupancy count and the shift register loaded on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      shift_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        shift_reg  <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Frame FSM state, baud counter, bit index and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      idx_reg   <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      idx_reg   <= idx_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic: each bit lasts one full baud-counter period; the stop
  // bit's last cycle chains straight into the next start bit when data waits.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_wrap ? '0 : baud_reg + BW'(1);
    idx_next   = idx_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_next = DATA;
          idx_next   = 3'd0;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (idx_reg != 3'd7) begin
            idx_next = idx_reg + 3'd1;
            tx_next  = shift_reg[idx_next];
          end else begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = ^shift_reg;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_wrap) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx at DIV=10 (1 MHz clock, 100 kbaud).
// Frame width follows UART_TX_PARITY_EN (10 or 11 bit periods).
module tb_uart_tx;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV        = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] fifo_count;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;

  logic [7:0]  bytes [16];
  logic [15:0] par_tab;
  logic [10:0] frame80;

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fifo_count(fifo_count),
    .busy      (busy),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line image LSB-first: start, 8 data bits, [parity], stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par);
    logic [10:0] f;
    f      = 11'h7FF;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (FB == 11) f[9] = par;
    return f;
  endfunction

  // Called just after the edge that drives the start bit; returns just after
  // the edge that ends the stop bit.
  task automatic check_frame(input logic [7:0] b, input logic par, input string tag);
    logic [10:0] f;
    f = make_frame(b, par);
    for (int j = 0; j < FB * DIV; j++) begin
      chk({tag, "_tx"}, 32'(tx), 32'(f[j / DIV]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      step();
    end
    $display("frame %s byte=%02h checks=%0d errors=%0d", tag, b, checks, errors);
  endtask

  initial begin
    bytes = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
              8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h81};
    par_tab = 16'h2AAA;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;

    // Reset, then 50 idle cycles.
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(in_ready), 32'd1);
      chk("idle_count", 32'(fifo_count), 32'd0);
      step();
    end
    $display("idle after reset checks=%0d errors=%0d", checks, errors);

    // Single byte 0xA5 pushed at edge k.
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("a5_count_k", 32'(fifo_count), 32'd1);
    chk("a5_tx_k", 32'(tx), 32'd1);
    chk("a5_busy_k", 32'(busy), 32'd1);
    step();
    chk("a5_count_k1", 32'(fifo_count), 32'd0);
    check_frame(8'hA5, 1'b0, "a5");
    chk("a5_busy_end", 32'(busy), 32'd0);
    chk("a5_tx_end", 32'(tx), 32'd1);

    // Back-to-back 0x55, 0x0F.
    in_data = 8'h55; in_valid = 1'b1;
    step();
    in_data = 8'h0F;
    step();
    in_valid = 1'b0;
    chk("b2b_count", 32'(fifo_count), 32'd1);
    check_frame(8'h55, 1'b0, "b2b0");
    check_frame(8'h0F, 1'b0, "b2b1");
    chk("b2b_busy_end", 32'(busy), 32'd0);
    chk("b2b_tx_end", 32'(tx), 32'd1);

    // FIFO full: frame 0x80 in flight, then 17 pushes.
    in_data = 8'h80; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("full_start_tx", 32'(tx), 32'd0);
    for (int i = 0; i < 17; i++) begin
      in_data  = (i == 16) ? 8'hEE : bytes[i];
      in_valid = 1'b1;
      chk($sformatf("full_ready%0d", i), 32'(in_ready), (i < 16) ? 32'd1 : 32'd0);
      step();
    end
    in_valid = 1'b0;
    chk("full_count", 32'(fifo_count), 32'd16);
    chk("full_ready_after", 32'(in_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    frame80 = make_frame(8'h80, 1'b1);
    for (int j = 17; j < FB * DIV; j++) begin
      chk("full_f80_tx", 32'(tx), 32'(frame80[j / DIV]));
      step();
    end
    for (int i = 0; i < 16; i++) begin
      check_frame(bytes[i], par_tab[i], $sformatf("fifo%0d", i));
    end
    chk("full_busy_end", 32'(busy), 32'd0);
    chk("full_count_end", 32'(fifo_count), 32'd0);

    // Reset during data bit 3 of 0xFF with 0x00 queued.
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_data = 8'h00;
    step();
    in_valid = 1'b0;
    repeat (44) step();
    chk("rst1_tx_pre", 32'(tx), 32'd1);
    chk("rst1_count_pre", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    step();
    chk("rst1_tx", 32'(tx), 32'd1);
    chk("rst1_busy", 32'(busy), 32'd0);
    chk("rst1_count", 32'(fifo_count), 32'd0);
    chk("rst1_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 150; i++) begin
      chk("rst1_quiet_tx", 32'(tx), 32'd1);
      chk("rst1_quiet_busy", 32'(busy), 32'd0);
      step();
    end
    $display("reset mid-frame 0xFF checks=%0d errors=%0d", checks, errors);

    // Reset during data bit 3 of 0x00, where the line is low.
    in_data = 8'h00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    repeat (44) step();
    chk("rst2_tx_pre", 32'(tx), 32'd0);
    rst = 1'b1;
    step();
    chk("rst2_tx", 32'(tx), 32'd1);
    chk("rst2_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      chk("rst2_quiet_tx", 32'(tx), 32'd1);
      step();
    end
    $display("reset mid-frame 0x00 checks=%0d errors=%0d", checks, errors);

    // Parity vectors: 0x07 -> parity 1, 0x03 -> parity 0.
    in_data = 8'h07; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_frame(8'h07, 1'b1, "par07");
    chk("par07_busy_end", 32'(busy), 32'd0);
    in_data = 8'h03; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_frame(8'h03, 1'b0, "par03");
    chk("par03_busy_end", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
